// File: rtl/regs_wb_arb.sv
// regs_wb_arb: write-back arbiter and read-forwarding unit for the 32x32 register file.
// Two write-back requesters share the single write port. Round-robin arbitration
// decides which one gets it, and each requester uses a valid/ready handshake.
// The granted write is registered onto we/reg_Wt_addr/wdata. That in-flight write
// is forwarded onto both read ports.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   reqN_valid/addr/data/ready     write-back requester N (0: ALU, 1: load)
//   we, reg_Wt_addr, wdata         registered write port to the register file
//   reg_Rd_addr_A, reg_Rt_addr_B   read addresses (also go to the register file)
//   rdata_A, rdata_B               raw read data from the register file
//   fwd_rdata_A, fwd_rdata_B       forwarded read data for consumers
//   conflict_cnt                   saturating count of cycles with both requesters valid
module regs_wb_arb #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          we,
    output logic [AW-1:0] reg_Wt_addr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] reg_Rd_addr_A,
    input  logic [AW-1:0] reg_Rt_addr_B,
    input  logic [DW-1:0] rdata_A,
    input  logic [DW-1:0] rdata_B,
    output logic [DW-1:0] fwd_rdata_A,
    output logic [DW-1:0] fwd_rdata_B,
    output logic [CW-1:0] conflict_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant0_c, grant1_c;

    // Round-robin grant: a lone requester always wins, and ptr breaks ties.
    always_comb begin
        grant0_c = req0_valid & (~req1_valid | ~ptr_q);
        grant1_c = req1_valid & (~req0_valid |  ptr_q);
    end

    // Ready is suppressed while reset is held, because the flops cannot capture then.
    assign req0_ready = grant0_c & rst;
    assign req1_ready = grant1_c & rst;

    // Next-state: load the granted write, drop r0 writes, and advance the pointer past the winner.
    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (grant0_c) begin
            we_d   = (req0_addr != '0);
            addr_d = req0_addr;
            data_d = req0_data;
            ptr_d  = 1'b1;
        end else if (grant1_c) begin
            we_d   = (req1_addr != '0);
            addr_d = req1_addr;
            data_d = req1_data;
            ptr_d  = 1'b0;
        end
        if (req0_valid && req1_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign we           = we_q;
    assign reg_Wt_addr  = addr_q;
    assign wdata        = data_q;
    assign conflict_cnt = cnt_q;

    // Bypass the write that the register file has not absorbed yet. r0 never matches because we_q is 0 for it.
    assign fwd_rdata_A = (we_q && (addr_q == reg_Rd_addr_A)) ? data_q : rdata_A;
    assign fwd_rdata_B = (we_q && (addr_q == reg_Rt_addr_B)) ? data_q : rdata_B;

endmodule

// File: tb/tb_regs_wb_arb.sv
// tb_regs_wb_arb: self-checking bench for regs_wb_arb.
// A behavioural model tracks whose turn it is, the pending write and the register
// file contents. A small register-file stand-in driven by the DUT write port
// supplies the raw read data.
module tb_regs_wb_arb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          we;
    logic [AW-1:0] reg_Wt_addr, reg_Rd_addr_A, reg_Rt_addr_B;
    logic [DW-1:0] wdata, rdata_A, rdata_B, fwd_rdata_A, fwd_rdata_B;
    logic [CW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    regs_wb_arb #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .we(we), .reg_Wt_addr(reg_Wt_addr), .wdata(wdata),
        .reg_Rd_addr_A(reg_Rd_addr_A), .reg_Rt_addr_B(reg_Rt_addr_B),
        .rdata_A(rdata_A), .rdata_B(rdata_B),
        .fwd_rdata_A(fwd_rdata_A), .fwd_rdata_B(fwd_rdata_B),
        .conflict_cnt(conflict_cnt)
    );

    // Register-file stand-in fed by the DUT write port.
    logic [DW-1:0] rf_env [32] = '{default: '0};
    always @(posedge clk) if (we && reg_Wt_addr != 0) rf_env[reg_Wt_addr] <= wdata;
    assign rdata_A = rf_env[reg_Rd_addr_A];
    assign rdata_B = rf_env[reg_Rt_addr_B];

    // Reference model state.
    logic [DW-1:0] ref_rf [32] = '{default: '0};
    int            turn;        // requester favoured on a tie
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_cnt;
    bit            m_g0, m_g1;  // grants taken at the most recent edge
    int            n_pass = 0;
    int            n_total = 0;

    function automatic logic exp_ready(input int who);
        int winner;
        if (!rst) return 1'b0;
        if (req0_valid && req1_valid) winner = turn;
        else if (req0_valid) winner = 0;
        else if (req1_valid) winner = 1;
        else winner = -1;
        return (winner == who);
    endfunction

    function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] a);
        return (m_we && m_addr == a) ? m_data : ref_rf[a];
    endfunction

    task automatic model_reset();
        turn = 0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_g0 = 0; m_g1 = 0;
    endtask

    // Apply one rising edge to the model using the inputs present at that edge.
    task automatic model_edge();
        bit g0, g1;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_we) ref_rf[m_addr] = m_data;
        g0 = exp_ready(0);
        g1 = exp_ready(1);
        if (req0_valid && req1_valid && m_cnt < (1 << CW) - 1) m_cnt++;
        m_we = 0;
        if (g0) begin
            m_we = (req0_addr != 0); m_addr = req0_addr; m_data = req0_data; turn = 1;
        end else if (g1) begin
            m_we = (req1_addr != 0); m_addr = req1_addr; m_data = req1_data; turn = 0;
        end
        m_g0 = g0; m_g1 = g1;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h1;
        req1_valid = 1; req1_addr = 5'd4; req1_data = 32'h2;
        reg_Rd_addr_A = '0; reg_Rt_addr_B = '0;
        model_reset();
        clk_edge(); clk_edge();
        @(negedge clk);
        n_total++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0: got %b exp 0", req0_ready); else n_pass++;
        n_total++; if (req1_ready !== 1'b0) $display("FAIL reset_ready1: got %b exp 0", req1_ready); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL reset_we: got %b exp 0", we); else n_pass++;
        n_total++; if (conflict_cnt !== '0) $display("FAIL reset_cnt: got %0d exp 0", conflict_cnt); else n_pass++;
        rst = 1'b1;
        req1_valid = 0; req0_addr = 5'd5; req0_data = 32'hA5A5A5A5;
        #1;
        n_total++; if (req0_ready !== 1'b1) $display("FAIL first_ready0: got %b exp 1", req0_ready); else n_pass++;
        clk_edge();
        n_total++; if (we !== 1'b1) $display("FAIL first_we: got %b exp 1", we); else n_pass++;
        n_total++; if (reg_Wt_addr !== 5'd5) $display("FAIL first_addr: got %0d exp 5", reg_Wt_addr); else n_pass++;
        n_total++; if (wdata !== 32'hA5A5A5A5) $display("FAIL first_data: got %h exp a5a5a5a5", wdata); else n_pass++;
        req0_valid = 0; reg_Rd_addr_A = 5'd5;
        #1;
        n_total++; if (fwd_rdata_A !== 32'hA5A5A5A5) $display("FAIL first_fwd: got %h exp a5a5a5a5", fwd_rdata_A); else n_pass++;
        clk_edge();
        n_total++; if (rdata_A !== 32'hA5A5A5A5) $display("FAIL first_regs: got %h exp a5a5a5a5", rdata_A); else n_pass++;
    endtask

    task automatic test_round_robin();
        // A lone req1 transfer leaves req0 favoured for the dual phase.
        req1_valid = 1; req1_addr = 5'd6; req1_data = 32'h0;
        clk_edge();
        req0_valid = 1; req0_addr = 5'd5; req0_data = 32'h11111111;
        req1_valid = 1; req1_addr = 5'd6; req1_data = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1))
                $display("FAIL rr_grant%0d: got r0=%b r1=%b exp r%0d", i, req0_ready, req1_ready, i % 2);
            else n_pass++;
            clk_edge();
            n_total++; if (wdata !== m_data) $display("FAIL rr_wdata%0d: got %h exp %h", i, wdata, m_data); else n_pass++;
            if (m_g0) req0_data = req0_data + 1;
            if (m_g1) req1_data = req1_data + 1;
        end
        req0_valid = 0; req1_valid = 0;
        n_total++; if (conflict_cnt !== CW'(4)) $display("FAIL rr_cnt: got %0d exp 4", conflict_cnt); else n_pass++;
        clk_edge();
    endtask

    task automatic test_r0_discard();
        req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h99;
        clk_edge();
        req0_valid = 0;
        req1_valid = 1; req1_addr = 5'd0; req1_data = 32'hAAAA5555;
        #1;
        n_total++; if (req1_ready !== 1'b1) $display("FAIL r0_ready1: got %b exp 1", req1_ready); else n_pass++;
        clk_edge();
        req1_valid = 0; reg_Rd_addr_A = 5'd0;
        #1;
        n_total++; if (we !== 1'b0) $display("FAIL r0_we: got %b exp 0", we); else n_pass++;
        n_total++; if (fwd_rdata_A !== '0) $display("FAIL r0_fwd: got %h exp 0", fwd_rdata_A); else n_pass++;
        // Pointer moved past req1, so a tie now goes to req0.
        req0_valid = 1; req0_addr = 5'd10; req0_data = 32'h10;
        req1_valid = 1; req1_addr = 5'd11; req1_data = 32'h11;
        #1;
        n_total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL r0_ptr: got r0=%b r1=%b exp r0", req0_ready, req1_ready);
        else n_pass++;
        clk_edge();
        req0_valid = 0; req1_valid = 0;
        clk_edge();
        n_total++; if (rdata_A !== '0) $display("FAIL r0_regs: got %h exp 0", rdata_A); else n_pass++;
    endtask

    task automatic test_forwarding();
        logic [DW-1:0] old6;
        reg_Rd_addr_A = 5'd6; reg_Rt_addr_B = 5'd6;
        old6 = ref_rf[6];
        req0_valid = 1; req0_addr = 5'd6; req0_data = 32'h55AA55AA;
        clk_edge();
        req0_valid = 0;
        #1;
        n_total++; if (fwd_rdata_A !== 32'h55AA55AA) $display("FAIL fwd_A: got %h exp 55aa55aa", fwd_rdata_A); else n_pass++;
        n_total++; if (fwd_rdata_B !== 32'h55AA55AA) $display("FAIL fwd_B: got %h exp 55aa55aa", fwd_rdata_B); else n_pass++;
        n_total++; if (rdata_A !== old6) $display("FAIL fwd_raw_old: got %h exp %h", rdata_A, old6); else n_pass++;
        clk_edge();
        n_total++; if (rdata_A !== 32'h55AA55AA) $display("FAIL fwd_raw_new: got %h exp 55aa55aa", rdata_A); else n_pass++;
        n_total++; if (fwd_rdata_B !== 32'h55AA55AA) $display("FAIL fwd_B_after: got %h exp 55aa55aa", fwd_rdata_B); else n_pass++;
    endtask

    task automatic test_random();
        req0_valid = 0; req1_valid = 0; m_g0 = 0; m_g1 = 0;
        for (int i = 0; i < 300; i++) begin
            // Requesters keep valid/addr/data stable until their transfer.
            if (!req0_valid || m_g0) begin
                req0_valid = ($urandom % 4) != 0;
                req0_addr = AW'($urandom_range(0, 31)); req0_data = $urandom;
            end
            if (!req1_valid || m_g1) begin
                req1_valid = ($urandom % 4) != 0;
                req1_addr = AW'($urandom_range(0, 31)); req1_data = $urandom;
            end
            reg_Rd_addr_A = ($urandom % 2) ? m_addr : AW'($urandom_range(0, 31));
            reg_Rt_addr_B = ($urandom % 2) ? m_addr : AW'($urandom_range(0, 31));
            @(negedge clk);
            n_total++; if (req0_ready !== exp_ready(0)) $display("FAIL rnd_ready0 @%0d: got %b exp %b", i, req0_ready, exp_ready(0)); else n_pass++;
            n_total++; if (req1_ready !== exp_ready(1)) $display("FAIL rnd_ready1 @%0d: got %b exp %b", i, req1_ready, exp_ready(1)); else n_pass++;
            n_total++; if (fwd_rdata_A !== exp_fwd(reg_Rd_addr_A)) $display("FAIL rnd_fwdA @%0d: got %h exp %h", i, fwd_rdata_A, exp_fwd(reg_Rd_addr_A)); else n_pass++;
            n_total++; if (fwd_rdata_B !== exp_fwd(reg_Rt_addr_B)) $display("FAIL rnd_fwdB @%0d: got %h exp %h", i, fwd_rdata_B, exp_fwd(reg_Rt_addr_B)); else n_pass++;
            clk_edge();
            n_total++; if (we !== m_we) $display("FAIL rnd_we @%0d: got %b exp %b", i, we, m_we); else n_pass++;
            n_total++; if (m_we && reg_Wt_addr !== m_addr) $display("FAIL rnd_addr @%0d: got %0d exp %0d", i, reg_Wt_addr, m_addr); else n_pass++;
            n_total++; if (m_we && wdata !== m_data) $display("FAIL rnd_data @%0d: got %h exp %h", i, wdata, m_data); else n_pass++;
            n_total++; if (conflict_cnt !== CW'(m_cnt)) $display("FAIL rnd_cnt @%0d: got %0d exp %0d", i, conflict_cnt, m_cnt); else n_pass++;
        end
        req0_valid = 0; req1_valid = 0;
        clk_edge();
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] old7;
        reg_Rd_addr_A = 5'd7;
        old7 = ref_rf[7];
        req0_valid = 1; req0_addr = 5'd7; req0_data = 32'hDEADBEEF;
        clk_edge();
        req0_valid = 0;
        n_total++; if (we !== 1'b1) $display("FAIL mid_we_before: got %b exp 1", we); else n_pass++;
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_total++; if (we !== 1'b0) $display("FAIL mid_we_drop: got %b exp 0", we); else n_pass++;
        n_total++; if (wdata !== '0 || reg_Wt_addr !== '0) $display("FAIL mid_clear: got addr %0d data %h exp 0", reg_Wt_addr, wdata); else n_pass++;
        n_total++; if (conflict_cnt !== '0) $display("FAIL mid_cnt: got %0d exp 0", conflict_cnt); else n_pass++;
        rst = 1'b1;
        req0_valid = 1; req0_addr = 5'd8; req0_data = 32'h8;
        req1_valid = 1; req1_addr = 5'd9; req1_data = 32'h9;
        #1;
        n_total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL mid_ptr: got r0=%b r1=%b exp r0", req0_ready, req1_ready);
        else n_pass++;
        clk_edge();
        req0_valid = 0; req1_valid = 0;
        clk_edge();
        n_total++; if (rdata_A !== old7) $display("FAIL mid_r7: got %h exp %h", rdata_A, old7); else n_pass++;
    endtask

    task automatic test_saturation();
        req0_valid = 1; req0_addr = 5'd12; req0_data = 32'hC;
        req1_valid = 1; req1_addr = 5'd13; req1_data = 32'hD;
        for (int i = 0; i < 20; i++) clk_edge();
        n_total++; if (conflict_cnt !== CW'(15)) $display("FAIL sat_cnt: got %0d exp 15", conflict_cnt); else n_pass++;
        clk_edge();
        n_total++; if (conflict_cnt !== CW'(m_cnt)) $display("FAIL sat_hold: got %0d exp %0d", conflict_cnt, m_cnt); else n_pass++;
        req0_valid = 0; req1_valid = 0;
        clk_edge();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_r0_discard();
        test_forwarding();
        test_random();
        test_mid_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regs_wb_arb.md
# regs_wb_arb

Write-back arbiter and read-forwarding unit in front of the 32x32 register file `regs`. It shares the single write port between two write-back requesters (req0: ALU result, req1: memory load) using round-robin arbitration and a valid/ready handshake. It registers the granted write onto `we`/`reg_Wt_addr`/`wdata`. It forwards the in-flight write onto both read ports so consumers never see stale data during the write window.

## Interface
Parameters:
- DW, 32, data width
- AW, 5, register address width
- CW, 16, conflict counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  AW  requester 0 destination register
- req0_data  in  DW  requester 0 write data
- req0_ready  out  1  requester 0 granted this cycle
- req1_valid / req1_addr / req1_data / req1_ready  same as req0, for requester 1
- we  out  1  to regs write enable
- reg_Wt_addr  out  AW  to regs write address
- wdata  out  DW  to regs write data
- reg_Rd_addr_A, reg_Rt_addr_B  in  AW  read addresses, also driven to regs
- rdata_A, rdata_B  in  DW  raw read data from regs
- fwd_rdata_A, fwd_rdata_B  out  DW  forwarded read data to consumers
- conflict_cnt  out  CW  count of cycles with both requesters valid

## Operation
- Reset (rst=0, asynchronous): we=0, reg_Wt_addr=0, wdata=0, conflict_cnt=0, priority pointer ptr=0 (req0 favoured), req0_ready=req1_ready=0.
- Grant logic is combinational from the current inputs and ptr:
  - grant0 = req0_valid & (!req1_valid | ptr==0)
  - grant1 = req1_valid & (!req0_valid | ptr==1)
  - reqN_ready = grantN while rst=1.
  - At most one grant per cycle.
- Handshake: a transfer occurs when valid & ready are both high at a rising edge. A requester holds valid, addr and data stable until it sees ready. It may deassert valid only after a transfer. The arbiter never stalls on its own, so throughput is one write per cycle.
- Pointer: after a transfer on requester i, ptr becomes the other requester. It is unchanged in cycles with no transfer. Under continuous dual requests, grants alternate 0,1,0,1 starting with the current ptr.
- Output register, on each edge:
  - With a transfer: we = (addr != 0), and reg_Wt_addr/wdata load the granted addr/data.
  - Without a transfer: we=0; addr/data hold.
  - A write to r0 is accepted (ready given, ptr advances) but discarded (we stays 0).
- Same-address writes from both requesters are serialized in grant order, so the later grant wins in regs.
- Forwarding: fwd_rdata_A = wdata when we=1 & reg_Wt_addr==reg_Rd_addr_A; otherwise rdata_A. Port B is identical with reg_Rt_addr_B. It is purely combinational, and r0 is never forwarded because we=0 for addr 0.
- conflict_cnt increments on each edge where req0_valid & req1_valid, and saturates at 2^CW-1.

## Timing
- Transfer at edge k → we/reg_Wt_addr/wdata valid from edge k to edge k+1 → regs updated at edge k+1 → raw rdata correct from edge k+1.
- Forwarded data is correct from edge k onward, so write-to-read latency seen by consumers is 1 cycle.
- ready is combinational from valid. No combinational path exists from ready back to valid inside the block.
- Reset asserted mid-operation: outputs clear immediately and any in-flight write (we=1) is dropped. The requester's transaction counts as completed if it was already accepted. After release, the first grant favours req0.
- Reset release: first transfer possible at the first rising edge with rst=1.

## Test plan
- Reset: hold rst=0 with both valid → ready both 0, we=0, conflict_cnt=0. Release, req0 (addr 5, data A5A5A5A5) alone → ready0=1, next cycle we=1, reg_Wt_addr=5, wdata=A5A5A5A5; regs r5 reads A5A5A5A5 after the following edge.
- Round-robin: both valid continuously for 4 cycles (req0→r5/11111111, req1→r6/22222222, each presenting a new value after its transfer) → grant order 0,1,0,1; conflict_cnt=4.
- r0 discard: req1 writes addr 0, data AAAA5555 → ready1=1 and ptr flips; we stays 0; regs r0 still reads 0.
- Forwarding: req0 writes r6=55AA55AA while reg_Rd_addr_A=6 and reg_Rt_addr_B=6 → fwd_rdata_A=fwd_rdata_B=55AA55AA during the we cycle, while raw rdata_A still holds the old value.
- Mid-write reset: rst pulses low while we=1 for r7=DEADBEEF → we drops immediately, r7 unchanged, ptr=0 after release. With conflict_cnt at 2^CW-1 and both valid, the counter holds its value.
